// File: rtl/cubehash_pkg.sv
// Shared definitions for the CubeHash core arbiter: state encoding,
// default block width and the requester index type.
package cubehash_pkg;

    localparam int BLOCK_W = 256;

    // One-hot state encoding; each state owns exactly one bit.
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_FIRST = 5'b00010,
        ST_WAIT  = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_ABORT = 5'b10000
    } arb_state_e;

    // Requester index: 0 -> requester 0, 1 -> requester 1.
    typedef logic req_idx_t;

    // Convert a one-hot two-way grant into a requester index.
    function automatic req_idx_t gnt_to_idx(input logic [1:0] g);
        return g[1];
    endfunction

endpackage

// File: rtl/cubehash_rr_pick.sv
// Two-way round-robin pick. ptr=0 favours req0, ptr=1 favours req1.
// Output is one-hot, or 2'b00 when nobody requests.
module cubehash_rr_pick (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    // Favoured requester wins a tie; a lone requester always wins.
    always_comb begin
        gnt_o = 2'b00;
        if (ptr_i == 1'b0) begin
            if (req0_i)      gnt_o = 2'b01;
            else if (req1_i) gnt_o = 2'b10;
        end else begin
            if (req1_i)      gnt_o = 2'b10;
            else if (req0_i) gnt_o = 2'b01;
        end
    end

endmodule

// File: rtl/cubehash_arbiter.sv
// Two-requester arbiter in front of a CubeHash core controller.
// Optional watchdog: define CUBEHASH_ARB_WATCHDOG_EN to abort a message
// that sits in WAIT_STOP or DRAIN for WD_CYCLES cycles.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no owner; grant on next request (not while hash_vld shows)
// FIRST     | start asserted; first block accepted from 2nd cycle on
// WAIT_STOP | core absorbing; next block accepted only with core_stop
// DRAIN     | last block taken; waiting for core_out_en
// ABORT     | one-cycle abandon pulse, pointer toggled, back to IDLE
module cubehash_arbiter
    import cubehash_pkg::*;
#(
    parameter int BW        = BLOCK_W,
    parameter int WD_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_p,
    input  logic          req0,
    input  logic          req1,
    input  logic          vld0,
    input  logic          vld1,
    input  logic          last0,
    input  logic          last1,
    input  logic [BW-1:0] data0,
    input  logic [BW-1:0] data1,
    output logic          rdy0,
    output logic          rdy1,
    output logic [1:0]    gnt,
    output logic          core_in_en,
    output logic          core_start,
    output logic          core_done,
    output logic [BW-1:0] core_blk,
    input  logic          core_stop,
    input  logic          core_err,
    input  logic          core_out_en,
    output logic          hash_vld,
    output logic          hash_owner,
    output logic          abort
);

    arb_state_e state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [1:0] gnt_q, gnt_d;
    req_idx_t   owner_q, owner_d;
    logic       hash_vld_q, hash_vld_d;
    req_idx_t   hash_owner_q, hash_owner_d;
    logic       fst2_q;
    logic       accept;
    logic [1:0] pick;
    logic       own_req, own_vld, own_last;

    cubehash_rr_pick u_pick (
        .req0_i (req0),
        .req1_i (req1),
        .ptr_i  (ptr_q),
        .gnt_o  (pick)
    );

    // Owner-side view of the request interface; the non-owner is ignored.
    assign own_req  = owner_q ? req1  : req0;
    assign own_vld  = owner_q ? vld1  : vld0;
    assign own_last = owner_q ? last1 : last0;

`ifdef CUBEHASH_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_hit;

    // Watchdog fires on the cycle that would bring the count to WD_CYCLES.
    assign wd_hit = (wd_q == WD_W'(WD_CYCLES - 1));

    // Count dwell time in WAIT_STOP/DRAIN; restart on every state change.
    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q)
            wd_d = '0;
        else if (state_q == ST_WAIT || state_q == ST_DRAIN)
            wd_d = wd_q + 1'b1;
    end

    // Watchdog count register.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`endif

    // Next-state, grant, pointer and block-acceptance decode.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        hash_vld_d   = 1'b0;
        hash_owner_d = hash_owner_q;
        accept       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Hold off granting during the hash_vld cycle.
                if (!hash_vld_q && pick != 2'b00) begin
                    gnt_d   = pick;
                    owner_d = gnt_to_idx(pick);
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (core_err || !own_req) begin
                    state_d = ST_ABORT;
                    gnt_d   = 2'b00;
                    ptr_d   = ~ptr_q;
                end else if (fst2_q && own_vld) begin
                    accept  = 1'b1;
                    state_d = own_last ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_err || !own_req) begin
                    state_d = ST_ABORT;
                    gnt_d   = 2'b00;
                    ptr_d   = ~ptr_q;
                end else if (core_stop && own_vld) begin
                    accept = 1'b1;
                    if (own_last) state_d = ST_DRAIN;
                end
`ifdef CUBEHASH_ARB_WATCHDOG_EN
                else if (wd_hit) begin
                    state_d = ST_ABORT;
                    gnt_d   = 2'b00;
                    ptr_d   = ~ptr_q;
                end
`endif
            end
            ST_DRAIN: begin
                if (core_err) begin
                    state_d = ST_ABORT;
                    gnt_d   = 2'b00;
                    ptr_d   = ~ptr_q;
                end else if (core_out_en) begin
                    hash_vld_d   = 1'b1;
                    hash_owner_d = owner_q;
                    ptr_d        = ~ptr_q;
                    gnt_d        = 2'b00;
                    state_d      = ST_IDLE;
                end
`ifdef CUBEHASH_ARB_WATCHDOG_EN
                else if (wd_hit) begin
                    state_d = ST_ABORT;
                    gnt_d   = 2'b00;
                    ptr_d   = ~ptr_q;
                end
`endif
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State and registered-output flops; reset drops everything at once.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            gnt_q        <= 2'b00;
            owner_q      <= 1'b0;
            hash_vld_q   <= 1'b0;
            hash_owner_q <= 1'b0;
            fst2_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            hash_vld_q   <= hash_vld_d;
            hash_owner_q <= hash_owner_d;
            // High from the second consecutive FIRST cycle onward.
            fst2_q       <= (state_q == ST_FIRST);
        end
    end

    assign gnt        = gnt_q;
    assign core_in_en = (state_q == ST_FIRST) || (state_q == ST_WAIT);
    assign core_start = (state_q == ST_FIRST);
    assign core_done  = accept;
    assign rdy0       = accept & ~owner_q;
    assign rdy1       = accept &  owner_q;
    assign core_blk   = owner_q ? data1 : data0;
    assign hash_vld   = hash_vld_q;
    assign hash_owner = hash_owner_q;
    assign abort      = (state_q == ST_ABORT);

endmodule

// File: tb/tb_cubehash_arbiter.sv
// Directed bench for cubehash_arbiter. Core-side inputs are driven by hand.
// Build with CUBEHASH_ARB_WATCHDOG_EN to exercise the watchdog (WD_CYCLES=20).
module tb_cubehash_arbiter;

    localparam int BW = 256;
`ifdef CUBEHASH_ARB_WATCHDOG_EN
    localparam int TB_WD = 20;
`else
    localparam int TB_WD = 255;
`endif

    logic          clk, rst_p;
    logic          req0, req1, vld0, vld1, last0, last1;
    logic [BW-1:0] data0, data1;
    logic          rdy0, rdy1;
    logic [1:0]    gnt;
    logic          core_in_en, core_start, core_done;
    logic [BW-1:0] core_blk;
    logic          core_stop, core_err, core_out_en;
    logic          hash_vld, hash_owner, abort;

    int total = 0;
    int bad   = 0;

    cubehash_arbiter #(.BW(BW), .WD_CYCLES(TB_WD)) dut (
        .clk         (clk),
        .rst_p       (rst_p),
        .req0        (req0),
        .req1        (req1),
        .vld0        (vld0),
        .vld1        (vld1),
        .last0       (last0),
        .last1       (last1),
        .data0       (data0),
        .data1       (data1),
        .rdy0        (rdy0),
        .rdy1        (rdy1),
        .gnt         (gnt),
        .core_in_en  (core_in_en),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_blk    (core_blk),
        .core_stop   (core_stop),
        .core_err    (core_err),
        .core_out_en (core_out_en),
        .hash_vld    (hash_vld),
        .hash_owner  (hash_owner),
        .abort       (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; vld0 = 0; vld1 = 0; last0 = 0; last1 = 0;
        data0 = '0; data1 = '0;
        core_stop = 0; core_err = 0; core_out_en = 0;
    endtask

    task automatic do_reset();
        rst_p = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst_p = 1'b0;
        tick();
    endtask

    logic [6:0] stop_pat;
    logic [6:0] rdy_exp;
    int         cnt, viol, hv_cnt, first_abort;

    initial begin
        rst_p = 1'b1;
        clear_inputs();
        tick();
        tick();
        // Reset state
        chk("rst_gnt",    gnt, 2'b00);
        chk("rst_in_en",  core_in_en, 1'b0);
        chk("rst_start",  core_start, 1'b0);
        chk("rst_done",   core_done, 1'b0);
        chk("rst_hash",   hash_vld, 1'b0);
        chk("rst_abort",  abort, 1'b0);
        rst_p = 1'b0;
        tick();

        // ---- single-block message from requester 0 ----
        req0 = 1; vld0 = 1; last0 = 1;
        data0 = {8{32'hA5A5_0001}};
        #1;
        chk("t1_idle_gnt", gnt, 2'b00);
        tick();
        chk("t1_gnt",      gnt, 2'b01);
        chk("t1_start",    core_start, 1'b1);
        chk("t1_in_en",    core_in_en, 1'b1);
        chk("t1_done_c1",  core_done, 1'b0);
        chk("t1_rdy_c1",   rdy0, 1'b0);
        chk("t1_blk",      core_blk, {8{32'hA5A5_0001}});
        tick();
        chk("t1_done_c2",  core_done, 1'b1);
        chk("t1_rdy_c2",   rdy0, 1'b1);
        tick();
        vld0 = 0; last0 = 0;
        chk("t1_drain_in_en", core_in_en, 1'b0);
        chk("t1_drain_done",  core_done, 1'b0);
        core_out_en = 1;
        tick();
        core_out_en = 0;
        chk("t1_hash_vld",   hash_vld, 1'b1);
        chk("t1_hash_owner", hash_owner, 1'b0);
        chk("t1_gnt_clr",    gnt, 2'b00);
        // Both now request: no grant during hash_vld, then pointer=1 picks req1.
        req1 = 1;
        tick();
        chk("t1_no_regrant", gnt, 2'b00);
        chk("t1_hash_1cyc",  hash_vld, 1'b0);
        tick();
        chk("t1_ptr_gnt",    gnt, 2'b10);
        // Owner (req1) withdraws in FIRST.
        req1 = 0; req0 = 0;
        tick();
        chk("t1_drop_abort", abort, 1'b1);
        chk("t1_drop_gnt",   gnt, 2'b00);
        chk("t1_drop_in_en", core_in_en, 1'b0);
        tick();
        chk("t1_abort_1cyc", abort, 1'b0);

        // ---- simultaneous requests, three rounds ----
        do_reset();
        req0 = 1; req1 = 1; vld0 = 1; last0 = 1; vld1 = 1; last1 = 1;
        data0 = {8{32'h0000_00AA}}; data1 = {8{32'h0000_00BB}};
        tick();
        chk("t2_gnt_r0",  gnt, 2'b01);
        chk("t2_blk_r0",  core_blk, {8{32'h0000_00AA}});
        tick();
        chk("t2_rdy0",    rdy0, 1'b1);
        chk("t2_rdy1_no", rdy1, 1'b0);
        tick();
        core_out_en = 1;
        tick();
        core_out_en = 0;
        chk("t2_hv0",     hash_vld, 1'b1);
        chk("t2_ho0",     hash_owner, 1'b0);
        tick();
        tick();
        chk("t2_gnt_r1",  gnt, 2'b10);
        chk("t2_blk_r1",  core_blk, {8{32'h0000_00BB}});
        tick();
        chk("t2_rdy1",    rdy1, 1'b1);
        chk("t2_rdy0_no", rdy0, 1'b0);
        tick();
        core_out_en = 1;
        tick();
        core_out_en = 0;
        chk("t2_hv1",     hash_vld, 1'b1);
        chk("t2_ho1",     hash_owner, 1'b1);
        tick();
        tick();
        chk("t2_gnt_r2",  gnt, 2'b01);

        // ---- 3-block message from requester 1 with core_stop gating ----
        do_reset();
        req1 = 1; vld1 = 1; last1 = 0;
        stop_pat = 7'b1010000;   // bit i = core_stop in cycle i (0,1 are FIRST)
        rdy_exp  = 7'b1010010;
        cnt = 0; viol = 0;
        tick();
        for (int i = 0; i < 7; i++) begin
            core_stop = stop_pat[i];
            last1 = (cnt >= 2);
            #1;
            if (i >= 2 && core_done && !core_stop) viol++;
            chk($sformatf("t3_rdy1_c%0d", i), rdy1, rdy_exp[i]);
            if (rdy1) cnt++;
            tick();
        end
        core_stop = 0; vld1 = 0; last1 = 0;
        chk("t3_rdy_cnt",   cnt, 3);
        chk("t3_done_viol", viol, 0);
        chk("t3_drain_in_en", core_in_en, 1'b0);
        core_out_en = 1;
        tick();
        core_out_en = 0;
        chk("t3_hv",  hash_vld, 1'b1);
        chk("t3_ho",  hash_owner, 1'b1);

        // ---- core_err in WAIT_STOP ----
        do_reset();
        req0 = 1; vld0 = 1; last0 = 0;
        tick();
        tick();
        tick();
        vld0 = 0;
        chk("t4_wait_in_en", core_in_en, 1'b1);
        chk("t4_wait_start", core_start, 1'b0);
        core_err = 1;
        tick();
        core_err = 0;
        req1 = 1;
        chk("t4_abort",   abort, 1'b1);
        chk("t4_gnt",     gnt, 2'b00);
        chk("t4_in_en",   core_in_en, 1'b0);
        tick();
        chk("t4_abort_1", abort, 1'b0);
        chk("t4_idle_gnt", gnt, 2'b00);
        tick();
        chk("t4_ptr_gnt", gnt, 2'b10);

        // ---- owner drops req in WAIT_STOP; late core_out_en ignored ----
        do_reset();
        req0 = 1; vld0 = 1; last0 = 0;
        tick();
        tick();
        tick();
        vld0 = 0;
        req0 = 0;
        tick();
        chk("t5_abort", abort, 1'b1);
        hv_cnt = 0;
        core_out_en = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (hash_vld) hv_cnt++;
        end
        core_out_en = 0;
        chk("t5_no_hash", hv_cnt, 0);
        chk("t5_gnt",     gnt, 2'b00);

        // ---- asynchronous reset mid-message ----
        do_reset();
        req0 = 1;
        tick();
        chk("t6_in_en_pre", core_in_en, 1'b1);
        #2;
        rst_p = 1'b1;
        #1;
        chk("t6_in_en_rst", core_in_en, 1'b0);
        chk("t6_gnt_rst",   gnt, 2'b00);
        chk("t6_abort_rst", abort, 1'b0);
        chk("t6_hash_rst",  hash_vld, 1'b0);
        req0 = 0;
        tick();
        rst_p = 1'b0;
        tick();

        // ---- watchdog (or indefinite wait) in DRAIN ----
        do_reset();
        req0 = 1; vld0 = 1; last0 = 1;
        tick();
        tick();
        tick();
        vld0 = 0; last0 = 0;
        chk("t7_drain_in_en", core_in_en, 1'b0);
        first_abort = -1;
        for (int k = 0; k < 1001; k++) begin
            if (abort && first_abort < 0) first_abort = k;
            if (first_abort >= 0) break;
            tick();
        end
`ifdef CUBEHASH_ARB_WATCHDOG_EN
        chk("t7_wd_abort_at", first_abort, 20);
`else
        chk("t7_no_wd_abort", first_abort, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
